// File: rtl/mp_adder_seq_pkg.sv
// rtl/mp_adder_seq_pkg.sv - shared word width, state encoding and sizing helper
package mp_adder_seq_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Word index width; a single-word build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/CIA32Bit.sv
// rtl/CIA32Bit.sv - combinational 32-bit carry-increment adder, 8-bit blocks
module CIA32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    localparam int BLK  = 8;
    localparam int NBLK = 4;

    logic [NBLK:0] c;

    assign c[0] = cin;

    // Each block adds with carry-in 0, then increments when its carry-in is set.
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] raw;
        assign raw = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign s[g*BLK +: BLK] = raw[BLK-1:0] + {{(BLK-1){1'b0}}, c[g]};
        assign c[g+1] = raw[BLK] | (c[g] & (&raw[BLK-1:0]));
    end

    assign cout = c[NBLK];

endmodule

// File: rtl/mp_adder_seq.sv
// rtl/mp_adder_seq.sv - multi-precision add sequencer; optional subtract with MPADD_SUB_EN
module mp_adder_seq
    import mp_adder_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W*WORDS-1:0]   a,
    input  logic [WORD_W*WORDS-1:0]   b,
    input  logic                      cin,
`ifdef MPADD_SUB_EN
    input  logic                      op_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W*WORDS-1:0]   sum,
    output logic                      cout
);

    localparam int unsigned OPW  = WORD_W * WORDS;
    localparam int unsigned IDXW = idx_width(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_t            state;
    state_t            state_nx;
    logic [OPW-1:0]    a_r;
    logic [OPW-1:0]    b_r;
    logic [OPW-1:0]    work_r;
    logic [OPW-1:0]    work_nx;
    logic [OPW-1:0]    sum_r;
    logic              carry_r;
    logic              cout_r;
    logic [IDXW-1:0]   idx;
    logic [31:0]       word_a;
    logic [31:0]       word_b;
    logic [31:0]       word_s;
    logic              word_c;
    logic              accept;
    logic              last_word;
    logic              start_carry;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign accept    = in_valid && in_ready;
    assign last_word = (state == S_RUN) && (idx == LAST_IDX);
    assign word_a    = a_r[idx*WORD_W +: WORD_W];

`ifdef MPADD_SUB_EN
    logic sub_r;
    // Subtraction is a + ~b + 1: invert each B word and seed the chain with 1.
    assign word_b      = sub_r ? ~b_r[idx*WORD_W +: WORD_W] : b_r[idx*WORD_W +: WORD_W];
    assign start_carry = op_sub ? 1'b1 : cin;
`else
    assign word_b      = b_r[idx*WORD_W +: WORD_W];
    assign start_carry = cin;
`endif

    CIA32Bit u_cia (
        .a    (word_a),
        .b    (word_b),
        .cin  (carry_r),
        .s    (word_s),
        .cout (word_c)
    );

    // Working sum with the current word merged in; published to sum_r only at the end.
    always_comb begin
        work_nx = work_r;
        work_nx[idx*WORD_W +: WORD_W] = word_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: accept in IDLE, one word per RUN cycle, hold in DONE until drained.
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = accept ? S_RUN : S_IDLE;
            S_RUN:   state_nx = last_word ? S_DONE : S_RUN;
            S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture, word-serial carry chain and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx     <= '0;
`ifdef MPADD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= start_carry;
            idx     <= '0;
`ifdef MPADD_SUB_EN
            sub_r   <= op_sub;
`endif
        end else if (state == S_RUN) begin
            work_r  <= work_nx;
            carry_r <= word_c;
            if (last_word) begin
                idx    <= '0;
                sum_r  <= work_nx;
                cout_r <= word_c;
            end else begin
                idx    <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_adder_seq.sv
// tb/tb_mp_adder_seq.sv - directed and randomized self-checking bench for mp_adder_seq
module tb_mp_adder_seq;

    localparam int WORDS = 4;
    localparam int OPW   = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] a = '0;
    logic [OPW-1:0] b = '0;
    logic           cin = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [OPW-1:0] sum;
    logic           cout;
`ifdef MPADD_SUB_EN
    logic           op_sub = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mp_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MPADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one operand set and return #1 after the accept edge.
    task automatic start_op(input logic [OPW-1:0] ta, input logic [OPW-1:0] tb_v,
                            input logic tc, input logic ts);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        a = ta;
        b = tb_v;
        cin = tc;
`ifdef MPADD_SUB_EN
        op_sub = ts;
`else
        if (ts) $display("note: subtract requested in add-only build");
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int bad_lat;
        logic stable;
        logic [OPW-1:0] ea;
        logic [OPW-1:0] eb;
        logic [OPW:0]   model;
        logic           ec;
        logic [31:0]    w;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: all-ones + 1 wraps to zero with carry out
        start_op({OPW{1'b1}}, 128'd1, 1'b0, 1'b0);
        check("t1_busy", in_ready, 0);
        wait_result(lat);
        check("t1_latency", lat, 4);
        check("t1_sum", sum, 0);
        check("t1_cout", cout, 1);
        check("t1_busy_done", in_ready, 0);
        finish_hs();
        check("t1_ready_after", in_ready, 1);
        check("t1_valid_after", out_valid, 0);

        // 2: carry crosses word 0 -> 1
        start_op(128'hFFFF0000, 128'h0000FFFF, 1'b1, 1'b0);
        wait_result(lat);
        check("t2_sum", sum, 128'h1_00000000);
        check("t2_cout", cout, 0);
        finish_hs();

        // 3: backpressure holds result, ignores inputs
        start_op(128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b1, 1'b0);
        wait_result(lat);
        ea = 128'h00000002_00000000_00000000_00000001;
        check("t3_sum", sum, ea);
        check("t3_cout", cout, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            if (sum !== ea || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("t3_stable", stable, 1);
        finish_hs();
        check("t3_ready_after", in_ready, 1);
        check("t3_hold", sum, ea);

        // 4: reset in second RUN cycle discards the op
        start_op({OPW{1'b1}}, {OPW{1'b1}}, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t4_valid", out_valid, 0);
        check("t4_sum", sum, 0);
        check("t4_cout", cout, 0);
        check("t4_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t4_no_partial", out_valid, 0);
        start_op(128'h78443C39, 128'h0019F7DD, 1'b0, 1'b0);
        wait_result(lat);
        check("t4_latency", lat, 4);
        check("t4_next_sum", sum, 128'h785E3416);
        check("t4_next_cout", cout, 0);
        finish_hs();

        // 5: random operands with all-ones word bias and random drain gaps
        bad_lat = 0;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < WORDS; k++) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w = 32'hFFFFFFFF;
                ea[k*32 +: 32] = w;
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w = 32'hFFFFFFFF;
                eb[k*32 +: 32] = w;
            end
            ec = 1'($urandom_range(0, 1));
            model = {1'b0, ea} + {1'b0, eb} + {{OPW{1'b0}}, ec};
            start_op(ea, eb, ec, 1'b0);
            wait_result(lat);
            if (lat != 4) bad_lat++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check("rand_result", {cout, sum}, model);
            finish_hs();
        end
        check("rand_latency_bad", bad_lat, 0);

`ifdef MPADD_SUB_EN
        // 6: subtract mode
        start_op(128'd5, 128'd7, 1'b0, 1'b1);
        wait_result(lat);
        check("t6_sub_neg_sum", sum, {{(OPW-1){1'b1}}, 1'b0});
        check("t6_sub_neg_cout", cout, 0);
        finish_hs();
        start_op(128'd7, 128'd5, 1'b0, 1'b1);
        wait_result(lat);
        check("t6_sub_pos_sum", sum, 128'd2);
        check("t6_sub_pos_cout", cout, 1);
        finish_hs();
        op_sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
